// File: rtl/genie_mem_responder.sv
// rtl/genie_mem_responder.sv - one-request-at-a-time responder fronting a synchronous single-port word SRAM
module genie_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wvalid,
  output logic              wready,
  input  logic [25:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [25:0]       raddr,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              oob_err
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, GAP} state_t;

  // Address bits above the implemented depth; any set bit marks an out-of-range request.
  localparam logic [25:0] HI_MASK = ~26'((27'd1 << ADDR_W) - 27'd1);
  localparam logic [3:0]  RD_CNT  = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_CNT  = 4'(WR_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        rd_oob;
  logic        rd_p1;
  logic        rd_cap;
  logic [31:0] rd_hold;
  logic        w_oob;
  logic        r_oob;
  logic [31:0] rd_data_in;

  assign w_oob      = |(waddr & HI_MASK);
  assign r_oob      = |(raddr & HI_MASK);
  assign rd_data_in = rd_oob ? 32'h0 : mem_rdata;

  // SRAM data lands in the cycle after mem_en; pass it straight through then, otherwise show the held copy.
  assign rdata = rd_cap ? rd_data_in : rd_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wready    <= 1'b0;
      rready    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      oob_err   <= 1'b0;
      rd_oob    <= 1'b0;
      rd_p1     <= 1'b0;
      rd_cap    <= 1'b0;
      rd_hold   <= 32'h0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      wready <= 1'b0;
      rready <= 1'b0;
      rd_p1  <= 1'b0;
      rd_cap <= rd_p1;
      if (rd_cap) rd_hold <= rd_data_in;

      case (state)
        IDLE: begin
          if (wvalid) begin
            mem_en    <= ~w_oob;
            mem_we    <= ~w_oob;
            mem_addr  <= waddr[ADDR_W-1:0];
            mem_wdata <= wdata;
            if (w_oob) oob_err <= 1'b1;
            if (WR_LAT == 1) begin
              state  <= WR_RESP;
              wready <= 1'b1;
            end else begin
              state <= WR_WAIT;
              cnt   <= WR_CNT;
            end
          end else if (rvalid) begin
            mem_en   <= ~r_oob;
            mem_addr <= raddr[ADDR_W-1:0];
            rd_oob   <= r_oob;
            rd_p1    <= 1'b1;
            if (r_oob) oob_err <= 1'b1;
            if (RD_LAT == 1) begin
              state  <= RD_RESP;
              rready <= 1'b1;
            end else begin
              state <= RD_WAIT;
              cnt   <= RD_CNT;
            end
          end
        end
        WR_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= WR_RESP;
            wready <= 1'b1;
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= RD_RESP;
            rready <= 1'b1;
          end
        end
        WR_RESP, RD_RESP: state <= GAP;
        GAP:              state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genie_mem_responder.sv
// tb/tb_genie_mem_responder.sv - scoreboard bench for genie_mem_responder
module tb_genie_mem_responder;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic              clk;
  logic              rst_n;
  logic              wvalid;
  logic              wready;
  logic [25:0]       waddr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic              rready;
  logic [25:0]       raddr;
  logic [31:0]       rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              oob_err;

  genie_mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_cnt = 0;
  always @(negedge clk) if (mem_en) en_cnt++;

  typedef struct {
    bit          rd;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (wready || rready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got wready=%0b rready=%0b at cyc=%0d, required no strobe", wready, rready, cyc);
      end else begin
        e = q.pop_front();
        if ((wready && rready) || (rready != e.rd) || (cyc != e.c) || (e.rd && rdata != e.d)) begin
          failures++;
          $display("FAIL strobe: got wready=%0b rready=%0b cyc=%0d rdata=%h, required rd=%0b cyc=%0d rdata=%h",
                   wready, rready, cyc, rdata, e.rd, e.c, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input bit rd, input logic [31:0] d, input int c);
    exp_t x;
    x.rd = rd; x.d = d; x.c = c;
    q.push_back(x);
  endtask

  // Waits for the strobe, drops the requested valids, then steps to the next IDLE cycle.
  task automatic wait_done(input bit rd, input bit drop_w, input bit drop_r);
    bit seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (rd ? rready : wready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: got no %s strobe in 30 cycles, required one", rd ? "rready" : "wready");
    end
    if (drop_w) wvalid = 1'b0;
    if (drop_r) rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [25:0] a, input logic [31:0] d);
    waddr = a; wdata = d; wvalid = 1'b1;
    push_exp(1'b0, 32'h0, cyc + WR_LAT);
    wait_done(1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_read(input logic [25:0] a, input logic [31:0] exp_d);
    raddr = a; rvalid = 1'b1;
    push_exp(1'b1, exp_d, cyc + RD_LAT);
    wait_done(1'b1, 1'b0, 1'b1);
  endtask

  logic [31:0] tbl [8] = '{32'h0000_0001, 32'h1111_2222, 32'hCAFE_F00D, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h1234_5678, 32'hA5A5_5A5A};
  int en_before;
  int k;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    wvalid = 1'b1; waddr = 26'h5; wdata = 32'h1111_1111;
    rvalid = 1'b1; raddr = 26'h5;

    // Reset held with both requests pending.
    repeat (3) @(negedge clk);
    check("rst_wready", {31'h0, wready}, 32'h0);
    check("rst_rready", {31'h0, rready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_oob_err", {31'h0, oob_err}, 32'h0);
    check("rst_en_cnt", en_cnt, 32'h0);

    // Release: write wins on the first IDLE cycle.
    rst_n = 1'b1;
    push_exp(1'b0, 32'h0, cyc + WR_LAT);
    wait_done(1'b0, 1'b1, 1'b1);
    check("rst_write_mem", mem[5], 32'h1111_1111);

    // Store then load.
    do_write(26'h123, 32'hDEAD_BEEF);
    do_read(26'h123, 32'hDEAD_BEEF);

    // Simultaneous write and read to the same address.
    waddr = 26'h10; wdata = 32'h5A5A_5A5A; wvalid = 1'b1;
    raddr = 26'h10; rvalid = 1'b1;
    push_exp(1'b0, 32'h0, cyc + WR_LAT);
    push_exp(1'b1, 32'h5A5A_5A5A, cyc + WR_LAT + 2 + RD_LAT);
    wait_done(1'b0, 1'b1, 1'b0);
    wait_done(1'b1, 1'b0, 1'b1);

    // Back-to-back reads with valid held throughout.
    for (int i = 0; i < 8; i++) do_write(26'h200 + 26'(i), tbl[i]);
    raddr = 26'h200; rvalid = 1'b1;
    k = cyc;
    for (int i = 0; i < 8; i++) push_exp(1'b1, tbl[i], k + RD_LAT + 4 * i);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (rready) break;
      end
      raddr = 26'h201 + 26'(i);
    end
    rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rdata_hold", rdata, 32'hA5A5_5A5A);

    // Out-of-range read then write.
    do_read(26'h0010000, 32'h0);
    check("oob_err_read", {31'h0, oob_err}, 32'h1);
    en_before = en_cnt;
    do_write(26'h0010000, 32'h7777_7777);
    check("oob_write_no_mem_en", en_cnt, en_before);
    check("oob_err_write", {31'h0, oob_err}, 32'h1);
    check("oob_no_alias", mem[0], 32'h0);

    // Reset during RD_WAIT drops the read.
    raddr = 26'h123; rvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_oob_cleared", {31'h0, oob_err}, 32'h0);
    check("mid_rst_rready", {31'h0, rready}, 32'h0);
    do_read(26'h10, 32'h5A5A_5A5A);

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
